// File: rtl/dice_pkg.sv
// Shared types and helpers for the dice roll scheduler.
//   state_t       : scheduler FSM states
//   FACE_MIN/MAX  : legal face range reported by the dice roller
//   is_valid_face : 1 when a sampled face lies in FACE_MIN..FACE_MAX
package dice_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_ROLL,
    ST_SETTLE,
    ST_SAMPLE,
    ST_REPORT
  } state_t;

  localparam logic [2:0] FACE_MIN = 3'd1;
  localparam logic [2:0] FACE_MAX = 3'd6;

  function automatic logic is_valid_face(input logic [2:0] face);
    return (face >= FACE_MIN) && (face <= FACE_MAX);
  endfunction

endpackage

// File: rtl/dice_roll_sched_rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
//   clk, rst : clock, asynchronous active-low reset (pointer -> 0)
//   req      : request vector
//   upd      : accept the current pick; pointer moves to winner+1
//   gnt      : one-hot pick (combinational)
//   id       : encoded pick (combinational)
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         upd,
  output logic [N-1:0] gnt,
  output logic [W-1:0] id
);

  logic [W-1:0] ptr;
  logic         found;
  int           idx;

  // Scan starting at the pointer, wrapping at N-1 -> 0; first hit wins.
  always_comb begin
    gnt   = '0;
    id    = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        id       = W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (upd) begin
      ptr <= (id == W'(N - 1)) ? '0 : id + 1'b1;
    end
  end

endmodule

// File: rtl/dice_roll_sched.sv
// Round-robin scheduler sharing one dice roller between NUM_PLAYERS players.
// Each turn: GRANT (1) -> ROLL (ROLL_CYCLES, dice_roll=1) -> SETTLE
// (SETTLE_CYCLES) -> SAMPLE (face registered) -> REPORT (1, res_valid=1).
// A saturating score per player is updated at REPORT.
// Optional build macro DICE_DOUBLE_EN: a face of 6 earns one bonus roll for
// the same player straight from REPORT (no IDLE, pointer not advanced).
//   clk, rst      : clock, asynchronous active-low reset
//   req           : per-player level request (sampled only in IDLE)
//   clr_scores    : synchronous clear of all scores (wins over an update)
//   score_sel     : player whose score appears on score_rd
//   dice_val      : face from the dice instance
//   dice_roll     : roll strobe to the dice instance
//   grant         : one-hot turn owner, GRANT..REPORT
//   busy          : FSM not IDLE
//   res_valid     : one-cycle result strobe; res_player/value/err hold
//   score_rd      : combinational score read
module dice_roll_sched import dice_pkg::*; #(
  parameter  int NUM_PLAYERS   = 4,
  parameter  int ROLL_CYCLES   = 4,
  parameter  int SETTLE_CYCLES = 1,
  parameter  int SCORE_W       = 8,
  localparam int PID_W         = $clog2(NUM_PLAYERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PLAYERS-1:0] req,
  input  logic                   clr_scores,
  input  logic [PID_W-1:0]       score_sel,
  input  logic [2:0]             dice_val,
  output logic                   dice_roll,
  output logic [NUM_PLAYERS-1:0] grant,
  output logic                   busy,
  output logic                   res_valid,
  output logic [PID_W-1:0]       res_player,
  output logic [2:0]             res_value,
  output logic                   res_err,
  output logic [SCORE_W-1:0]     score_rd
);

  localparam int CNT_MAX = (ROLL_CYCLES > SETTLE_CYCLES) ? ROLL_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         cnt;
  logic [NUM_PLAYERS-1:0]   grant_q;
  logic [NUM_PLAYERS-1:0]   arb_gnt;
  logic [PID_W-1:0]         arb_id;
  logic                     arb_upd;
  logic [PID_W-1:0]         cur_pid;
  logic                     roll_done, settle_done, bonus_take;
  logic [SCORE_W-1:0]       score [NUM_PLAYERS];

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [2:0]         b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {{(SCORE_W-2){1'b0}}, b};
    return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

  rr_arbiter #(.N(NUM_PLAYERS)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .upd (arb_upd),
    .gnt (arb_gnt),
    .id  (arb_id)
  );

  assign roll_done   = (cnt == CNT_W'(ROLL_CYCLES - 1));
  assign settle_done = (cnt == CNT_W'(SETTLE_CYCLES - 1));

`ifdef DICE_DOUBLE_EN
  logic bonus_used;
  // Only one bonus per turn; a 6 is always a valid face so res_err is implied 0.
  assign bonus_take = (res_value == FACE_MAX) && !bonus_used;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bonus_used <= 1'b0;
    end else if (state == ST_IDLE) begin
      bonus_used <= 1'b0;
    end else if (state == ST_REPORT && bonus_take) begin
      bonus_used <= 1'b1;
    end
  end
`else
  assign bonus_take = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    arb_upd   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          state_nxt = ST_GRANT;
          arb_upd   = 1'b1;
        end
      end
      ST_GRANT:  state_nxt = ST_ROLL;
      ST_ROLL:   if (roll_done)   state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_done) state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = ST_REPORT;
      ST_REPORT: state_nxt = bonus_take ? ST_GRANT : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Turn owner latch and phase counter (restarts on every state change)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      cur_pid <= '0;
      grant_q <= '0;
    end else begin
      if (state_nxt != state) cnt <= '0;
      else if (state == ST_ROLL || state == ST_SETTLE) cnt <= cnt + 1'b1;
      if (arb_upd) begin
        cur_pid <= arb_id;
        grant_q <= arb_gnt;
      end
    end
  end

  // Sample stage: result registers hold until the next SAMPLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_player <= '0;
      res_value  <= '0;
      res_err    <= 1'b0;
    end else if (state == ST_SAMPLE) begin
      res_player <= cur_pid;
      res_value  <= dice_val;
      res_err    <= !is_valid_face(dice_val);
    end
  end

  // Report stage: score update, clear takes priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PLAYERS; i++) score[i] <= '0;
    end else if (clr_scores) begin
      for (int i = 0; i < NUM_PLAYERS; i++) score[i] <= '0;
    end else if (state == ST_REPORT && !res_err) begin
      score[res_player] <= sat_add(score[res_player], res_value);
    end
  end

  assign busy      = (state != ST_IDLE);
  assign dice_roll = (state == ST_ROLL);
  assign res_valid = (state == ST_REPORT);
  assign grant     = busy ? grant_q : '0;
  assign score_rd  = score[score_sel];

endmodule

// File: doc/dice_roll_sched.md
Name: dice_roll_sched

Overview:
- Round-robin scheduler that shares one `dice` roller between NUM_PLAYERS requesters.
- Per turn it grants one player, drives the dice `roll` input for a fixed window, waits for settle, samples the 3-bit face (1..6) and reports it tagged with the player id.
- Keeps a saturating running score per player, readable through a select port.
- Sits directly above the dice instance in the game datapath.

Parameters:
- NUM_PLAYERS, 4: number of requesters (2..8).
- ROLL_CYCLES, 4: cycles `dice_roll` is held high per turn (>=1).
- SETTLE_CYCLES, 1: cycles with `dice_roll` low before sampling (>=1).
- SCORE_W, 8: per-player score width.
- PID_W, $clog2(NUM_PLAYERS): player-id width; derived localparam, not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req  in  NUM_PLAYERS  per-player roll request, level.
- clr_scores  in  1  synchronous clear of all scores.
- score_sel  in  PID_W  score read select.
- dice_val  in  3  face value from the dice instance.
- dice_roll  out  1  drives the dice `roll` input.
- grant  out  NUM_PLAYERS  one-hot current turn owner.
- busy  out  1  high whenever the FSM is not IDLE.
- res_valid  out  1  one-cycle result strobe.
- res_player  out  PID_W  player id of the result.
- res_value  out  3  raw sampled face.
- res_err  out  1  sampled face outside 1..6.
- score_rd  out  SCORE_W  score of the player selected by score_sel (combinational read).

Behaviour:
- Reset (async, rst=0):
  - FSM to IDLE; dice_roll, grant, busy, res_valid, res_err all 0.
  - res_player and res_value 0; all scores 0.
  - RR pointer set so player 0 has highest priority.
- FSM states: IDLE, GRANT, ROLL, SETTLE, SAMPLE, REPORT.
- IDLE: when any req bit is high at edge t, the round-robin pick is registered and the FSM enters GRANT at t+1.
  - Priority starts at last winner+1 and wraps at NUM_PLAYERS-1 -> 0.
- GRANT: 1 cycle; grant asserted from this state through REPORT inclusive.
- ROLL: dice_roll=1 for exactly ROLL_CYCLES cycles (t+2 .. t+1+ROLL_CYCLES).
- SETTLE: dice_roll=0 for SETTLE_CYCLES cycles.
- SAMPLE: dice_val registered.
- REPORT: 1 cycle.
  - res_valid=1; res_player, res_value, res_err valid.
  - Outputs hold their value until the next REPORT.
  - Next state is IDLE (or GRANT, see the optional feature).
- Latency: req seen in IDLE at t -> res_valid at t+3+ROLL_CYCLES+SETTLE_CYCLES (t+8 with defaults).
- Turn-to-turn gap: one IDLE cycle minimum between REPORT and the next GRANT.
- Request rules:
  - req dropping mid-turn does not abort the turn; the result is still reported.
  - req is ignored outside IDLE.
- Scoring (at REPORT):
  - If res_err=0: score[player] += value, saturating at 2^SCORE_W-1.
  - If res_err=1 (face 0 or 7): score is unchanged and res_value carries the raw face.
- clr_scores:
  - Zeroes all scores on the next edge.
  - If it coincides with a REPORT update, clear wins.
  - Does not disturb the FSM.
- Reset mid-turn: dice_roll and grant drop immediately (asynchronously) and no result is reported.

Optional Feature:
- Macro: DICE_DOUBLE_EN.
- Defined: a valid face of 6 earns a bonus roll.
  - REPORT goes directly to GRANT for the same player, regardless of req; the RR pointer does not advance.
  - Limited to one bonus per turn: a 6 on the bonus roll ends the turn normally.
  - Each roll is reported and scored separately.
- Undefined: 6 is an ordinary face and REPORT always goes to IDLE.

Decomposition:
- Package dice_pkg:
  - FSM state enum.
  - Face constants FACE_MIN=1, FACE_MAX=6.
  - Helper function is_valid_face.
- One sub-module: rr_arbiter, parameterized N.
  - Inputs: req vector, update strobe.
  - Outputs: one-hot grant, encoded id.
  - Owns the rotating pointer.

Test Plan:
- Reset: hold rst=0 with req=4'b1111 -> grant=0, dice_roll=0, busy=0, res_valid=0, score_rd=0 for every score_sel.
- Single request: req=4'b0100 at t, dice model returns 5 -> grant=4'b0100 over t+1..t+8; dice_roll high t+2..t+5; res_valid at t+8 with res_player=2, res_value=5; score 2 = 5.
- Fairness: req=4'b1111 held -> grant order 0,1,2,3,0,1; every turn is 8 cycles with a 1-cycle IDLE gap between turns.
- Error and saturation:
  - dice_val forced to 7 -> res_err=1, res_value=7, score unchanged.
  - With SCORE_W=4 and player 0 rolling 6 repeatedly -> scores 6, 12, 15, 15.
- Reset mid-ROLL: drop rst during the third ROLL cycle -> dice_roll goes 0 immediately and no res_valid; after release with req=4'b1000, player 3 is granted.
- DICE_DOUBLE_EN: player 1 rolls 6 then 6 -> two results for player 1 back-to-back with no IDLE between them; score 1 = 12; next grant goes to player 2.
